// File: rtl/lsu_pkg.sv
// Shared types and helpers for the queued load/store unit: opcode/funct3
// constants, the outstanding-transaction entry and byte-lane formatting.
package lsu_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Width of the rd field carried in each queue entry; the top's RD_W must match.
  localparam int LSU_RD_W = 5;

  typedef struct packed {
    logic                is_load;
    logic [2:0]          funct3;
    logic [1:0]          off;
    logic [LSU_RD_W-1:0] rd;
  } lsu_entry_t;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3[1:0])
      2'b00:   return {4{wdata[7:0]}};
      2'b01:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic access_err(input logic is_load, input logic [2:0] funct3,
                                      input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (is_load) illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    else         illegal = (funct3 > F3_W);
    misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                 ((funct3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] funct3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = rdata[{off[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'b0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'b0, h};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// In-order FIFO of granted-but-unanswered bus transactions; the head entry
// describes the next response to arrive.
module lsu_resp_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  lsu_entry_t                 entry_i,
  input  logic                       pop_i,
  output lsu_entry_t                 head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  lsu_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/lsu_queued.sv
// Queued load/store unit: registered req/gnt address phase, in-order
// rvalid responses tracked in a FIFO, registered load writeback.
module lsu_queued
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RD_W  = LSU_RD_W
) (
  input  logic            req,
  input  logic            reset,
  input  logic            op_valid_in,
  output logic            op_ready_out,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] wdata_in,
  input  logic [RD_W-1:0] rd_in,
  output logic            data_req_o,
  input  logic            data_gnt_in,
  output logic [XLEN-1:0] data_add_o,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [XLEN-1:0] data_wdata_o,
  input  logic            data_rvalid,
  input  logic [XLEN-1:0] data_rdata_in,
  output logic            wb_valid_out,
  output logic [RD_W-1:0] wb_rd_out,
  output logic [XLEN-1:0] wb_data_out,
  output logic            err_out,
  output logic            busy_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic            is_load, op_err, accept, push, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  lsu_entry_t      head, pend_q, pend_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] add_q, add_d, wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            err_q, wb_valid_q;
  logic [RD_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  assign is_load = (opcode_in == OPC_LOAD);
  assign op_err  = access_err(is_load, funct3_in, addr_in[1:0]);

  // A grant this cycle frees the request slot but claims a queue entry.
  assign occ          = {1'b0, count} + (CW + 1)'(data_gnt_in | req_q);
  assign op_ready_out = (!req_q || data_gnt_in) && (occ < DEPTH_C);
  assign accept       = op_valid_in && op_ready_out;

  assign push = req_q && data_gnt_in && !fifo_full;
  assign pop  = data_rvalid && !fifo_empty;

  always_comb begin
    req_d   = req_q;
    add_d   = add_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    pend_d  = pend_q;
    if (req_q && data_gnt_in) req_d = 1'b0;
    if (accept && !op_err) begin
      req_d          = 1'b1;
      add_d          = {addr_in[XLEN-1:2], 2'b00};
      we_d           = !is_load;
      be_d           = be_gen(funct3_in, addr_in[1:0]);
      wdata_d        = store_data(funct3_in, wdata_in);
      pend_d.is_load = is_load;
      pend_d.funct3  = funct3_in;
      pend_d.off     = addr_in[1:0];
      pend_d.rd      = LSU_RD_W'(rd_in);
    end
  end

  always_ff @(posedge req or negedge reset) begin
    if (!reset) begin
      req_q      <= 1'b0;
      add_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      req_q      <= req_d;
      add_q      <= add_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      pend_q     <= pend_d;
      err_q      <= accept && op_err;
      wb_valid_q <= pop && head.is_load;
      if (pop && head.is_load) begin
        wb_rd_q   <= RD_W'(head.rd);
        wb_data_q <= load_fmt(head.funct3, head.off, data_rdata_in);
      end
    end
  end

  lsu_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (req),
    .rst_ni  (reset),
    .push_i  (push),
    .entry_i (pend_q),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign data_req_o   = req_q;
  assign data_add_o   = add_q;
  assign data_we_o    = we_q;
  assign data_be_o    = be_q;
  assign data_wdata_o = wdata_q;
  assign wb_valid_out = wb_valid_q;
  assign wb_rd_out    = wb_rd_q;
  assign wb_data_out  = wb_data_q;
  assign err_out      = err_q;
  assign busy_out     = req_q || !fifo_empty;

endmodule

// File: tb/tb_lsu_queued.sv
// Bench for lsu_queued: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the unit.
module tb_lsu_queued;

  localparam int DEPTH = 4;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk;
  logic        rst_n;
  logic        op_valid_in, op_ready_out;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  rd_in;
  logic        data_req_o, data_gnt_in, data_we_o, data_rvalid;
  logic [31:0] data_add_o, data_wdata_o, data_rdata_in;
  logic [3:0]  data_be_o;
  logic        wb_valid_out, err_out, busy_out;
  logic [4:0]  wb_rd_out;
  logic [31:0] wb_data_out;

  lsu_queued #(.XLEN(32), .DEPTH(DEPTH), .RD_W(5)) dut (
    .req(clk), .reset(rst_n),
    .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
    .opcode_in(opcode_in), .funct3_in(funct3_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .rd_in(rd_in),
    .data_req_o(data_req_o), .data_gnt_in(data_gnt_in), .data_add_o(data_add_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid(data_rvalid), .data_rdata_in(data_rdata_in),
    .wb_valid_out(wb_valid_out), .wb_rd_out(wb_rd_out), .wb_data_out(wb_data_out),
    .err_out(err_out), .busy_out(busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit is_load; int f3; int off; int rd; } ent_t;

  ent_t        q[$];
  bit          m_pend, m_we;
  logic [31:0] m_add, m_wdata;
  logic [3:0]  m_be;
  ent_t        m_pent;
  bit          e_wb, e_err;
  int          e_rd;
  logic [31:0] e_wbdata;
  bit          last_acc, last_grant;
  int          checks, errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_err(bit ld, int f3, int off);
    bit illegal;
    illegal = ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
    return illegal || ((off % m_size(f3)) != 0);
  endfunction

  function automatic logic [31:0] m_fmt(int f3, int off, logic [31:0] rdata);
    logic [31:0] s;
    int v;
    s = rdata >> (8 * off);
    case (f3)
      0: begin v = int'(s & 32'hFF);   return (v >= 128)   ? v - 256   : v; end
      1: begin v = int'(s & 32'hFFFF); return (v >= 32768) ? v - 65536 : v; end
      4: return s & 32'hFF;
      5: return s & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] m_be_f(int f3, int off);
    int nb;
    nb = m_size(f3);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(int f3, logic [31:0] wd);
    case (f3 % 4)
      0: return (wd & 32'hFF) * 32'h01010101;
      1: return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  task automatic check_outs();
    chk("req", data_req_o, m_pend);
    if (m_pend) begin
      chk("add", data_add_o, m_add);
      chk("be", data_be_o, m_be);
      chk("we", data_we_o, m_we);
      if (m_we) chk("wdata", data_wdata_o, m_wdata);
    end
    chk("wb_valid", wb_valid_out, e_wb);
    if (e_wb) begin
      chk("wb_rd", wb_rd_out, e_rd);
      chk("wb_data", wb_data_out, e_wbdata);
    end
    chk("err", err_out, e_err);
    chk("busy", busy_out, m_pend || q.size() > 0);
  endtask

  // Called one time unit after a rising edge; returns at the same point of the next cycle.
  task automatic step(input bit ov, input logic [6:0] opc, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input bit g, input bit rv, input logic [31:0] rdat);
    bit   mready, acc, grant, ld;
    int   off, fi;
    ent_t e;
    check_outs();
    op_valid_in   = ov;
    opcode_in     = ov ? opc : 7'd0;
    funct3_in     = f3;
    addr_in       = a;
    wdata_in      = wd;
    rd_in         = rd;
    data_gnt_in   = g;
    data_rvalid   = rv && (q.size() > 0);
    data_rdata_in = rdat;
    #1;
    mready = g ? (q.size() + 1 < DEPTH) : (!m_pend && q.size() < DEPTH);
    chk("ready", op_ready_out, mready);
    acc   = ov && mready;
    grant = m_pend && g;
    e_wb  = 0;
    e_err = 0;
    if (data_rvalid) begin
      e        = q.pop_front();
      e_wb     = e.is_load;
      e_rd     = e.rd;
      e_wbdata = m_fmt(e.f3, e.off, rdat);
    end
    if (grant) begin
      q.push_back(m_pent);
      m_pend = 0;
    end
    if (acc) begin
      ld  = (opc == LD);
      off = int'(a % 4);
      fi  = int'(f3);
      if (m_err(ld, fi, off)) e_err = 1;
      else begin
        m_pend  = 1;
        m_add   = a & ~32'h3;
        m_be    = m_be_f(fi, off);
        m_we    = !ld;
        m_wdata = m_wd(fi, wd);
        m_pent  = '{is_load: ld, f3: fi, off: off, rd: int'(rd)};
      end
    end
    last_acc   = acc;
    last_grant = grant;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit g, input bit rv, input logic [31:0] rdat);
    step(0, LD, 3'd0, 32'h0, 32'h0, 5'd0, g, rv, rdat);
  endtask

  task automatic load_rt(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] rdat);
    step(1, LD, f3, a, 32'h0, rd, 0, 0, 0);
    idle(1, 0, 0);
    idle(0, 1, rdat);
  endtask

  initial begin
    int dut_gr, rdn, guard;
    checks = 0; errors = 0;
    m_pend = 0; e_wb = 0; e_err = 0;
    rst_n = 1'b0;
    op_valid_in = 0; opcode_in = 0; funct3_in = 0; addr_in = 0; wdata_in = 0; rd_in = 0;
    data_gnt_in = 0; data_rvalid = 0; data_rdata_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", data_req_o, 0);
    chk("rst_wb_valid", wb_valid_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_add", data_add_o, 0);
    chk("rst_wb_data", wb_data_out, 0);
    rst_n = 1'b1;

    // Word store, granted in the first request cycle
    step(1, ST, 3'd2, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0);
    chk("sw_req", data_req_o, 1);
    chk("sw_add", data_add_o, 32'h100);
    chk("sw_be", data_be_o, 4'b1111);
    chk("sw_we", data_we_o, 1);
    chk("sw_wdata", data_wdata_o, 32'hDEADBEEF);
    idle(1, 0, 0);
    chk("sw_req_drop", data_req_o, 0);
    idle(0, 1, 32'h0);
    chk("sw_no_wb", wb_valid_out, 0);

    load_rt(3'd0, 32'h103, 5'd5, 32'h80123456);
    chk("lb_valid", wb_valid_out, 1);
    chk("lb_rd", wb_rd_out, 5);
    chk("lb_data", wb_data_out, 32'hFFFFFF80);
    load_rt(3'd4, 32'h103, 5'd5, 32'h80123456);
    chk("lbu_data", wb_data_out, 32'h00000080);
    load_rt(3'd5, 32'h102, 5'd7, 32'h80123456);
    chk("lhu_data", wb_data_out, 32'h00008012);

    step(1, ST, 3'd1, 32'h102, 32'h0000ABCD, 5'd0, 0, 0, 0);
    chk("sh_be", data_be_o, 4'b1100);
    chk("sh_wdata", data_wdata_o, 32'hABCDABCD);
    idle(1, 0, 0);
    idle(0, 1, 32'h0);

    step(1, LD, 3'd2, 32'h101, 32'h0, 5'd3, 0, 0, 0);
    chk("lw_mis_err", err_out, 1);
    chk("lw_mis_req", data_req_o, 0);
    chk("lw_mis_busy", busy_out, 0);
    idle(0, 0, 0);
    chk("lw_mis_err_end", err_out, 0);
    chk("lw_mis_no_wb", wb_valid_out, 0);

    // Back-to-back loads with grant held high until the queue fills
    dut_gr = 0;
    rdn = 1;
    for (int c = 0; c < 8; c++) begin
      if (data_req_o) dut_gr++;
      step(1, LD, 3'd2, 32'h200 + 4 * rdn, 32'h0, 5'(rdn), 1, 0, 0);
      if (last_acc) rdn++;
    end
    chk("b2b_grants", dut_gr, 4);
    op_valid_in = 1; data_gnt_in = 1;
    #1;
    chk("b2b_full_ready", op_ready_out, 0);
    idle(0, 1, 32'hCAFEF00D);
    chk("b2b_first_rd", wb_rd_out, 1);
    chk("b2b_first_data", wb_data_out, 32'hCAFEF00D);
    op_valid_in = 0; data_gnt_in = 0;
    #1;
    chk("b2b_ready_back", op_ready_out, 1);
    for (int i = 0; i < 3; i++) begin
      idle(0, 1, $urandom);
      chk("b2b_order", wb_rd_out, i + 2);
    end

    // Asynchronous reset with three entries outstanding and a request pending
    for (int c = 0; c < 4; c++) step(1, LD, 3'd2, 32'h300 + 4 * c, 32'h0, 5'(10 + c), 1, 0, 0);
    chk("prerst_req", data_req_o, 1);
    op_valid_in = 0; data_gnt_in = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", data_req_o, 0);
    chk("arst_busy", busy_out, 0);
    chk("arst_wb_valid", wb_valid_out, 0);
    chk("arst_add", data_add_o, 0);
    chk("arst_be", data_be_o, 0);
    q.delete();
    m_pend = 0; e_wb = 0; e_err = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load_rt(3'd2, 32'h40, 5'd9, 32'h12345678);
    chk("post_rst_valid", wb_valid_out, 1);
    chk("post_rst_rd", wb_rd_out, 9);
    chk("post_rst_data", wb_data_out, 32'h12345678);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom % 10) < 6, ($urandom % 2) ? LD : ST, 3'($urandom % 8), $urandom,
           $urandom, 5'($urandom % 32), 1'($urandom % 2), ($urandom % 10) < 4, $urandom);
    end
    guard = 0;
    while ((m_pend || q.size() > 0) && guard < 100) begin
      idle(1, 1, $urandom);
      guard++;
    end
    chk("drain_done", (m_pend || q.size() > 0), 0);
    idle(0, 0, 0);
    chk("final_busy", busy_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_queued.md
Name: lsu_queued

Overview:
Parametrised load/store unit that replaces the single-shot LSU between execute and the data-memory bus.
- Accepts one memory op per cycle from execute and drives the data bus with a req/gnt address phase and an rvalid response phase.
- Tracks up to DEPTH outstanding transactions in order.
- Formats load data (byte/half/word, signed/unsigned) and returns a registered writeback (rd, data) to the register file.
- Adds byte-enable generation, store-data replication, misalignment/illegal-funct3 trapping and back-pressure.

Parameters:
XLEN, 32, data/address width (byte-lane logic is fixed at 4 lanes; XLEN other than 32 is unsupported)
DEPTH, 4, maximum outstanding granted transactions (power of 2, >=2)
RD_W, 5, destination register index width

Ports:
req  in  1  clock; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset
op_valid_in  in  1  execute presents a memory op
op_ready_out  out  1  LSU can accept op this cycle
opcode_in  in  7  0000011 load, 0100011 store; other values are never presented with op_valid_in
funct3_in  in  3  RV32 size/sign field
addr_in  in  XLEN  effective address
wdata_in  in  XLEN  store data (rs2)
rd_in  in  RD_W  load destination
data_req_o  out  1  bus address-phase request
data_gnt_in  in  1  bus grant
data_add_o  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
data_we_o  out  1  1 = store
data_be_o  out  4  byte enables
data_wdata_o  out  XLEN  lane-aligned store data
data_rvalid  in  1  response valid (loads and stores)
data_rdata_in  in  XLEN  response data
wb_valid_out  out  1  writeback strobe
wb_rd_out  out  RD_W  writeback register
wb_data_out  out  XLEN  formatted load data
err_out  out  1  one-cycle pulse: misaligned or illegal funct3
busy_out  out  1  request pending or any entry outstanding

Behaviour:
- Reset (reset low, async): every output, pending request and queue pointers/count cleared to 0. data_req_o drops immediately. In-flight responses are discarded.
- Accept: op_valid_in && op_ready_out at edge N. data_req_o and address/be/we/wdata are registered and valid from N+1.
- op_ready_out = (!data_req_o || data_gnt_in) && (count + data_req_o < DEPTH) when data_gnt_in is low; when data_gnt_in is high, count + 1 < DEPTH. Combinational, no dependence on op_valid_in.
- Address phase: data_req_o and all address-phase outputs are held stable until data_gnt_in. On grant, the LSU pushes entry {is_load, funct3, addr[1:0], rd} and deasserts data_req_o unless a new op is accepted in the same cycle (back-to-back).
- Response: each data_rvalid pops the head entry.
  - Load: the cycle after rvalid, wb_valid_out=1, wb_rd_out=entry.rd, wb_data_out=formatted data. Latency is 1 cycle.
  - Store: pop only, no writeback.
  - Load with rd=0: writeback still issued; regs ignores it.
- Simultaneous push (grant) and pop (rvalid): count unchanged, both pointers advance.
- data_rvalid with an empty queue: ignored; the bench asserts it never happens.
- Load formatting (off = addr[1:0]):
  - LB/LBU: byte rdata[8*off+:8], sign- or zero-extended.
  - LH/LHU: half rdata[16*off[1]+:16], sign- or zero-extended.
  - LW: full word.
- Store lanes:
  - SB: be = 4'b0001<<off, wdata = byte replicated x4.
  - SH: be = 4'b0011<<off, wdata = half replicated x2.
  - SW: be = 4'b1111.
- Errors: half access with off[0]=1, word access with off!=0, load funct3 in {011,110,111}, or store funct3 >010.
  - The op is accepted (ready rules apply) and issues no bus request or queue entry.
  - err_out pulses at N+1.
  - No writeback.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.

Decomposition:
- Package lsu_pkg holds:
  - opcode constants OPC_LOAD, OPC_STORE
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - typedef struct lsu_entry_t {is_load, funct3, off, rd}
  - functions be_gen(), load_fmt()
- Sub-module lsu_resp_fifo: parametric synchronous FIFO of lsu_entry_t (push, pop, full, empty, count), DEPTH entries, same clock/reset.

Test Plan:
- SW addr 0x100 wdata 0xDEADBEEF, gnt in same cycle as req: data_req_o=1 one cycle with add=0x100, be=1111, we=1, wdata=0xDEADBEEF; rvalid produces no wb_valid_out.
- LB addr 0x103 rd=5, rdata 0x80123456: one cycle after rvalid, wb_valid_out=1, wb_rd_out=5, wb_data_out=0xFFFFFF80. Same op with LBU gives 0x00000080.
- LHU addr 0x102, rdata 0x80123456: wb_data_out=0x00008012. SH addr 0x102 wdata 0x0000ABCD: be=1100, wdata=0xABCDABCD.
- LW addr 0x101: err_out pulses for 1 cycle; data_req_o stays 0; no writeback; busy_out stays 0.
- DEPTH=4, gnt always high, rvalid withheld, 6 back-to-back loads: exactly 4 grants, then op_ready_out=0. One rvalid: writeback for the first load at the next cycle, op_ready_out back to 1. In-order rd order verified.
- Reset low while 3 entries are outstanding and data_req_o=1: all outputs 0 immediately. After release, a new LW completes with correct rd; stale rvalids are not issued by the bench.
